// File: rtl/wave_measure_module.sv
// Period / max / min / peak-to-peak measurement of a periodic 8-bit ADC waveform.
// Optional macro WAVE_MEASURE_AVG4_EN: average the period over four consecutive cycles.
module wave_measure_module #(
  parameter logic [7:0]    MID     = 8'd128,
  parameter logic [7:0]    HYST    = 8'd8,
  parameter int            PW      = 16,
  parameter logic [PW-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          Sample_En,
  input  logic [7:0]    ADC_Data,
  input  logic          Start_In,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout,
  output logic [PW-1:0] Period_Out,
  output logic [7:0]    Vmax_Out,
  output logic [7:0]    Vmin_Out,
  output logic [7:0]    Vpp_Out
);

`ifdef WAVE_MEASURE_AVG4_EN
  localparam int SW = PW + 2;
`else
  localparam int SW = PW;
`endif

  // Thresholds in 9 bits so MID+HYST cannot wrap and MID-HYST cannot underflow.
  localparam logic [8:0] HI_TH = {1'b0, MID} + {1'b0, HYST};
  localparam logic [8:0] LO_TH = (MID >= HYST) ? {1'b0, MID - HYST} : 9'd0;

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  state_t        state_q, state_d;
  logic          schmitt_q, schmitt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [7:0]    max_q, max_d;
  logic [7:0]    min_q, min_d;
  logic [PW-1:0] period_q, period_d;
  logic [7:0]    vmax_q, vmax_d;
  logic [7:0]    vmin_q, vmin_d;
  logic [7:0]    vpp_q, vpp_d;
`ifdef WAVE_MEASURE_AVG4_EN
  logic [1:0]    nrise_q, nrise_d;
`endif

  logic          is_hi, is_lo, rise, tmo_last;
  logic [PW-1:0] cnt_inc;
  logic [7:0]    fold_max, fold_min;

  assign is_hi    = {1'b0, ADC_Data} >= HI_TH;
  assign is_lo    = {1'b0, ADC_Data} <= LO_TH;
  assign rise     = Sample_En && !schmitt_q && is_hi;
  assign tmo_last = (tmo_q == TIMEOUT - 1'b1);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign fold_max = (ADC_Data > max_q) ? ADC_Data : max_q;
  assign fold_min = (ADC_Data < min_q) ? ADC_Data : min_q;

  always_comb begin
    schmitt_d = schmitt_q;
    if (Sample_En) begin
      if (is_hi)      schmitt_d = 1'b1;
      else if (is_lo) schmitt_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    sum_d     = sum_q;
    max_d     = max_q;
    min_d     = min_q;
    period_d  = period_q;
    vmax_d    = vmax_q;
    vmin_d    = vmin_q;
    vpp_d     = vpp_q;
`ifdef WAVE_MEASURE_AVG4_EN
    nrise_d   = nrise_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start_In) begin
          state_d = ARM;
          busy_d  = 1'b1;
          cnt_d   = '0;
          tmo_d   = '0;
          sum_d   = '0;
`ifdef WAVE_MEASURE_AVG4_EN
          nrise_d = '0;
`endif
        end
      end
      ARM: begin
        if (Sample_En) begin
          if (rise) begin
            state_d = MEAS;
            cnt_d   = {{(PW-1){1'b0}}, 1'b1};
            tmo_d   = '0;
            max_d   = ADC_Data;
            min_d   = ADC_Data;
          end else if (tmo_last) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      MEAS: begin
        if (Sample_En) begin
          if (rise) begin
            sum_d = sum_q + SW'(cnt_q);
`ifdef WAVE_MEASURE_AVG4_EN
            // Intermediate edges open the next period, so their sample is kept.
            if (nrise_q == 2'd3) begin
              state_d = DONE;
            end else begin
              nrise_d = nrise_q + 1'b1;
              cnt_d   = {{(PW-1){1'b0}}, 1'b1};
              tmo_d   = '0;
              max_d   = fold_max;
              min_d   = fold_min;
            end
`else
            state_d = DONE;
`endif
          end else if (tmo_last) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
          end else begin
            max_d = fold_max;
            min_d = fold_min;
            cnt_d = cnt_inc;
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef WAVE_MEASURE_AVG4_EN
        period_d = sum_q[SW-1:2];
`else
        period_d = sum_q;
`endif
        vmax_d = max_q;
        vmin_d = min_q;
        vpp_d  = max_q - min_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      schmitt_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      period_q  <= '0;
      vmax_q    <= '0;
      vmin_q    <= '0;
      vpp_q     <= '0;
`ifdef WAVE_MEASURE_AVG4_EN
      nrise_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      schmitt_q <= schmitt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      min_q     <= min_d;
      period_q  <= period_d;
      vmax_q    <= vmax_d;
      vmin_q    <= vmin_d;
      vpp_q     <= vpp_d;
`ifdef WAVE_MEASURE_AVG4_EN
      nrise_q   <= nrise_d;
`endif
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Timeout    = timeout_q;
  assign Period_Out = period_q;
  assign Vmax_Out   = vmax_q;
  assign Vmin_Out   = vmin_q;
  assign Vpp_Out    = vpp_q;

endmodule
